// File: rtl/obsidian_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and memory (slave).
interface obsidian_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/obsidian_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with a terminal HALT.
// Define OBSIDIAN_STEP_EN to add a `step` input that gates one instruction per pulse.
module obsidian_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
`ifdef OBSIDIAN_STEP_EN
  input  logic                        step,
`endif
  obsidian_sequencer_if.master        imem,
  output logic [31:0]                 instr,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_target,
  output logic                        rf_we,
  output logic [31:0]                 pc,
  output logic [2:0]                  state,
  output logic                        halted,
  output logic [15:0]                 retire_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [31:0] STEP     = 32'(PC_STEP);
  localparam logic [5:0]  OP_HALT  = 6'h3F;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] retire_q, retire_d;
  // Set on the first edge after reset so IDLE cannot leave before the second edge.
  logic        armed_q;
  logic        go_fetch, wb_continue;

`ifdef OBSIDIAN_STEP_EN
  assign go_fetch    = step;
  assign wb_continue = 1'b0;
`else
  assign go_fetch    = run;
  assign wb_continue = run;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      retire_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
      armed_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    case (state_q)
      S_IDLE: begin
        if (armed_q && go_fetch) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (instr_q[31:26] == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d     = branch_taken ? {branch_target[31:2], 2'b00} : pc_q + STEP;
        retire_d = retire_q + 16'd1;
        state_d  = wb_continue ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset drops the fetch request asynchronously.
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign rf_we          = (state_q == S_WB);
  assign halted         = (state_q == S_HALT);
  assign state          = state_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign retire_count   = retire_q;

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_FETCH && !imem.imem_ack) |=> $stable(imem.imem_addr));
  a_halt_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HALT) |=> (state_q == S_HALT));

endmodule

// File: tb/tb_obsidian_sequencer.sv
// Scoreboarded bench: expected retirements queued with stimulus, checked on each rf_we.
module tb_obsidian_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, run, branch_taken;
  logic [31:0] branch_target;
`ifdef OBSIDIAN_STEP_EN
  logic        step;
`endif
  logic [31:0] instr, pc;
  logic        rf_we, halted;
  logic [2:0]  state;
  logic [15:0] retire_count;

  obsidian_sequencer_if ifc();

  obsidian_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef OBSIDIAN_STEP_EN
    .step(step),
`endif
    .imem(ifc), .instr(instr), .branch_taken(branch_taken), .branch_target(branch_target),
    .rf_we(rf_we), .pc(pc), .state(state), .halted(halted), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [15:0] cnt; } exp_t;
  exp_t        sb[$];
  int          errors = 0, checks = 0;
  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  bit          ack_ovr = 1'b0;
  logic [31:0] ovr_data = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory responder: ack after ack_delay wait cycles, or forced ack when ack_ovr is set.
  initial begin
    int wc;
    wc = 0;
    ifc.imem_ack = 1'b0;
    ifc.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_ovr) begin
        ifc.imem_ack = 1'b1; ifc.imem_rdata = ovr_data;
      end else if (ifc.imem_req === 1'b1) begin
        if (wc >= ack_delay) begin
          ifc.imem_ack = 1'b1; ifc.imem_rdata = rd(ifc.imem_addr); wc = 0;
        end else begin
          ifc.imem_ack = 1'b0; ifc.imem_rdata = 32'hDEAD_BEEF; wc++;
        end
      end else begin
        ifc.imem_ack = 1'b0; wc = 0;
      end
    end
  end

  // Retirement monitor: each rf_we pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rf_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_retire pc=%h cnt=%0d", pc, retire_count);
        end else begin
          e = sb.pop_front();
          if (pc !== e.pc || retire_count !== e.cnt) begin
            errors++;
            $display("FAIL sb_retire got pc=%h cnt=%0d want pc=%h cnt=%0d", pc, retire_count, e.pc, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic reset_release();
    rst_n = 1'b0; run = 1'b0; branch_taken = 1'b0; branch_target = '0;
`ifdef OBSIDIAN_STEP_EN
    step = 1'b0;
`endif
    ack_ovr = 1'b0; ack_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (state === s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_one(output bit ok);
    bit a, b;
    run = 1'b1;
    wait_state(3'd1, 5, a);
    run = 1'b0;
    wait_state(3'd0, 12, b);
    ok = a & b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; branch_taken = 1'b0; branch_target = '0;
`ifdef OBSIDIAN_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %b want 0", rf_we); end
    checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", ifc.imem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if (retire_count !== 16'h0) begin errors++; $display("FAIL rst_retire got %0d want 0", retire_count); end
  endtask

  task automatic test_sequential();
    int n, last, bad;
    rst_n = 1'b0; mem.delete(); ack_delay = 0; run = 1'b1;
    sb.push_back('{32'h0, 16'd0}); sb.push_back('{32'h4, 16'd1}); sb.push_back('{32'h8, 16'd2});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL seq_first_edge state got %0d want 0", state); end
    @(posedge clk); #1;
    checks++; if (state !== 3'd1 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_second_edge state=%0d req=%b addr=%h want 1 1 0", state, ifc.imem_req, ifc.imem_addr);
    end
    n = 0; last = -1; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (last >= 0 && c - last != 4) bad++;
        last = c; n++;
        if (n == 3) run = 1'b0;
      end
      if (n == 3 && state === 3'd0) break;
    end
    checks++; if (n != 3 || bad != 0) begin errors++; $display("FAIL seq_rf_we_pulses got n=%0d badgaps=%0d want 3 0", n, bad); end
    checks++; if (pc !== 32'd12 || retire_count !== 16'd3 || state !== 3'd0) begin
      errors++; $display("FAIL seq_final pc=%h cnt=%0d state=%0d want c 3 0", pc, retire_count, state);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL seq_sb_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_wait_states();
    bit ok;
    int reqc, addr_bad, latch_bad;
    reset_release();
    mem.delete(); mem[32'h0] = 32'h1234_5678; ack_delay = 3;
    sb.push_back('{32'h0, 16'd0});
    run = 1'b1;
    wait_state(3'd1, 5, ok);
    run = 1'b0;
    reqc = 0; addr_bad = 0; latch_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifc.imem_req !== 1'b1) break;
      reqc++;
      if (ifc.imem_addr !== 32'h0) addr_bad++;
      if (instr !== 32'h0) latch_bad++;
      @(negedge clk);
    end
    checks++; if (!ok || reqc != 4 || addr_bad != 0 || latch_bad != 0) begin
      errors++; $display("FAIL ws_req ok=%0d reqcycles=%0d addrbad=%0d early=%0d want 1 4 0 0", ok, reqc, addr_bad, latch_bad);
    end
    checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL ws_latch got %h want 12345678", instr); end
    ack_ovr = 1'b1; ovr_data = 32'h0BAD_0BAD;
    wait_state(3'd0, 12, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok || instr !== 32'h1234_5678 || state !== 3'd0) begin
      errors++; $display("FAIL ws_ack_ignored instr=%h state=%0d want 12345678 0", instr, state);
    end
    ack_ovr = 1'b0;
    checks++; if (retire_count !== 16'd1 || pc !== 32'h4) begin
      errors++; $display("FAIL ws_retire cnt=%0d pc=%h want 1 4", retire_count, pc);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ws_sb_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_branch();
    bit ok;
    reset_release();
    mem.delete();
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    sb.push_back('{32'h0, 16'd0});
    run_one(ok);
    checks++; if (!ok || pc !== 32'h0000_0100) begin errors++; $display("FAIL br_taken ok=%0d pc=%h want 1 100", ok, pc); end
    branch_target = 32'hFFFF_FFFF;
    sb.push_back('{32'h100, 16'd1});
    run_one(ok);
    checks++; if (!ok || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_align ok=%0d pc=%h want 1 fffffffc", ok, pc); end
    branch_taken = 1'b0;
    sb.push_back('{32'hFFFF_FFFC, 16'd2});
    run_one(ok);
    checks++; if (!ok || pc !== 32'h0 || retire_count !== 16'd3) begin
      errors++; $display("FAIL br_pc_wrap ok=%0d pc=%h cnt=%0d want 1 0 3", ok, pc, retire_count);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL br_sb_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_halt();
    bit ok;
    reset_release();
    mem.delete(); mem[32'h4] = 32'hFC00_0000;
    sb.push_back('{32'h0, 16'd0});
    run = 1'b1;
    wait_state(3'd5, 30, ok);
    checks++; if (!ok || halted !== 1'b1 || pc !== 32'h4 || retire_count !== 16'd1) begin
      errors++; $display("FAIL halt_enter ok=%0d halted=%b pc=%h cnt=%0d want 1 1 4 1", ok, halted, pc, retire_count);
    end
    ack_ovr = 1'b1; ovr_data = 32'h1111_1111;
    repeat (10) @(negedge clk);
    checks++; if (state !== 3'd5 || halted !== 1'b1 || pc !== 32'h4 || retire_count !== 16'd1 ||
                  instr !== 32'hFC00_0000 || rf_we !== 1'b0) begin
      errors++; $display("FAIL halt_frozen state=%0d pc=%h cnt=%0d instr=%h want 5 4 1 fc000000", state, pc, retire_count, instr);
    end
    ack_ovr = 1'b0; run = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (state !== 3'd0 || halted !== 1'b0 || pc !== 32'h0 || retire_count !== 16'd0) begin
      errors++; $display("FAIL halt_reset state=%0d halted=%b pc=%h cnt=%0d want 0 0 0 0", state, halted, pc, retire_count);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_sb_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    reset_release();
    mem.delete(); mem[32'h0] = 32'h0000_0ABC;
    sb.push_back('{32'h0, 16'd0});
    run_one(ok);
    checks++; if (!ok || pc !== 32'h4 || instr !== 32'h0000_0ABC) begin
      errors++; $display("FAIL mf_setup ok=%0d pc=%h instr=%h want 1 4 abc", ok, pc, instr);
    end
    ack_delay = 100; run = 1'b1;
    wait_state(3'd1, 5, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (!ok || ifc.imem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL mf_async req=%b state=%0d pc=%h instr=%h want 0 0 0 0", ifc.imem_req, state, pc, instr);
    end
    run = 1'b0; ack_ovr = 1'b1; ovr_data = 32'h5555_5555;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (instr !== 32'h0 || state !== 3'd0 || pc !== 32'h0 || retire_count !== 16'd0) begin
      errors++; $display("FAIL mf_ack_discard instr=%h state=%0d pc=%h cnt=%0d want 0 0 0 0", instr, state, pc, retire_count);
    end
    ack_ovr = 1'b0; ack_delay = 0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mf_sb_left got %0d want 0", sb.size()); end
  endtask

`ifdef OBSIDIAN_STEP_EN
  task automatic test_step();
    reset_release();
    mem.delete(); run = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL step_idle_hold state=%0d want 0", state); end
    sb.push_back('{32'h0, 16'd0}); sb.push_back('{32'h4, 16'd1});
    step = 1'b1; @(negedge clk); step = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (state !== 3'd0 || retire_count !== 16'd1) begin
      errors++; $display("FAIL step_first state=%0d cnt=%0d want 0 1", state, retire_count);
    end
    step = 1'b1; @(negedge clk); step = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (state !== 3'd0 || retire_count !== 16'd2 || pc !== 32'h8) begin
      errors++; $display("FAIL step_second state=%0d cnt=%0d pc=%h want 0 2 8", state, retire_count, pc);
    end
    run = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL step_sb_left got %0d want 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef OBSIDIAN_STEP_EN
    test_step();
`else
    test_sequential();
`endif
    test_wait_states();
    test_branch();
    test_halt();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/obsidian_sequencer.md
OBSIDIAN_SEQUENCER -- requirements
Module: obsidian_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the program counter value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, SHALL set the sequential program counter increment.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port run, input, 1, SHALL enable instruction sequencing.
REQ-006 Port imem_req, output, 1, SHALL request an instruction fetch.
REQ-007 Port imem_addr, output, 32, SHALL give the fetch address and always equal pc.
REQ-008 Port imem_ack, input, 1, SHALL indicate that imem_rdata is valid.
REQ-009 Port imem_rdata, input, 32, SHALL carry the fetched instruction word.
REQ-010 Port instr, output, 32, SHALL hold the latched instruction that drives the control unit.
REQ-011 Port branch_taken, input, 1, SHALL be sampled in WRITEBACK to select branch_target.
REQ-012 Port branch_target, input, 32, SHALL give the next pc when a branch is taken.
REQ-013 Port rf_we, output, 1, SHALL be the register-file write strobe.
REQ-014 Port pc, output, 32, SHALL give the current program counter.
REQ-015 Port state, output, 3, SHALL give the FSM encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
REQ-016 Port halted, output, 1, SHALL be high when and only when state is HALT.
REQ-017 Port retire_count, output, 16, SHALL count retired instructions.

Function
REQ-018 In IDLE, when run=1 the FSM SHALL go to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack=1.
REQ-020 On imem_ack=1 in FETCH, instr SHALL latch imem_rdata and the FSM SHALL go to DECODE.
REQ-021 imem_ack SHALL be ignored in every state other than FETCH.
REQ-022 If run deasserts during FETCH, the fetch SHALL still complete and the instruction SHALL retire.
REQ-023 In DECODE, if instr[31:26]==6'h3F (HALT opcode) the FSM SHALL go to HALT; otherwise it SHALL go to EXECUTE.
REQ-024 EXECUTE SHALL last exactly one cycle and then go to WRITEBACK.
REQ-025 In WRITEBACK, rf_we SHALL be 1 for exactly one cycle; rf_we SHALL be 0 in all other states.
REQ-026 In WRITEBACK, pc SHALL update to {branch_target[31:2],2'b00} if branch_taken=1, else to pc+PC_STEP modulo 2^32.
REQ-027 In WRITEBACK, retire_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-028 After WRITEBACK, the FSM SHALL go to FETCH if run=1, else to IDLE.
REQ-029 HALT SHALL be terminal and left only by reset; HALT SHALL NOT increment retire_count or change pc.
REQ-030 Non-branch latency SHALL be 4 cycles from first imem_req to the next imem_req with zero-wait memory (ack in the first FETCH cycle).

Reset
REQ-031 While rst_n=0, outputs SHALL be: state=IDLE, pc=RESET_PC, instr=0, rf_we=0, imem_req=0, halted=0, retire_count=0.
REQ-032 Reset asserted mid-fetch SHALL drop imem_req immediately (asynchronously), and the in-flight ack SHALL be discarded.
REQ-033 After rst_n rises, the first FETCH SHALL occur no earlier than the second rising edge of clk.

Configuration
REQ-034 With macro OBSIDIAN_STEP_EN defined, there SHALL be an input port step (1 bit); IDLE->FETCH SHALL require step=1 (run ignored in IDLE), and WRITEBACK SHALL always go to IDLE, giving exactly one instruction per step pulse.
REQ-035 Without OBSIDIAN_STEP_EN, port step SHALL be absent and behaviour SHALL follow REQ-018 and REQ-028.

Verification
REQ-036 Reset, run=1, ack same cycle, words 0x00000000 x3 -> pc 0,4,8,12; rf_we pulses once per 4 cycles; retire_count=3.
REQ-037 FETCH with ack delayed 3 cycles -> imem_req held high 4 cycles, imem_addr constant, a single instr latch.
REQ-038 branch_taken=1, branch_target=0x0000_0103 in WRITEBACK -> next pc=0x0000_0100.
REQ-039 Fetch of 0xFC00_0000 -> DECODE->HALT, halted=1, no rf_we, pc and retire_count frozen until rst_n pulse.
REQ-040 rst_n low during FETCH, then ack -> imem_req=0 immediately, instr=0, pc=RESET_PC, state=IDLE.
REQ-041 (OBSIDIAN_STEP_EN) run=1, two single-cycle step pulses 10 cycles apart -> exactly 2 retirements, state returns to IDLE between them.
